// File: rtl/mastermind_score_engine_if.sv
// Bus between the game core and the Mastermind scoring engine.
// master: game core / display side. slave: the scoring engine.
interface mastermind_score_engine_if #(
  parameter int unsigned NUM_SLOTS   = 4,
  parameter int unsigned COLOR_W     = 3,
  parameter int unsigned MAX_GUESSES = 6
);
  localparam int unsigned CODE_W  = NUM_SLOTS * COLOR_W;
  localparam int unsigned PEG_W   = $clog2(NUM_SLOTS + 1);
  localparam int unsigned COUNT_W = $clog2(MAX_GUESSES + 1);
  localparam int unsigned IDX_W   = $clog2(MAX_GUESSES);

  logic               start;
  logic [CODE_W-1:0]  guess;
  logic [CODE_W-1:0]  target;
  logic               clear;
  logic               busy;
  logic               done;
  logic [PEG_W-1:0]   black;
  logic [PEG_W-1:0]   white;
  logic               win;
  logic [COUNT_W-1:0] hist_count;
  logic               hist_full;
  logic [IDX_W-1:0]   hist_rd_idx;
  logic [CODE_W-1:0]  hist_rd_guess;
  logic [PEG_W-1:0]   hist_rd_black;
  logic [PEG_W-1:0]   hist_rd_white;

  modport master (
    output start, guess, target, clear, hist_rd_idx,
    input  busy, done, black, white, win, hist_count, hist_full,
    input  hist_rd_guess, hist_rd_black, hist_rd_white
  );

  modport slave (
    input  start, guess, target, clear, hist_rd_idx,
    output busy, done, black, white, win, hist_count, hist_full,
    output hist_rd_guess, hist_rd_black, hist_rd_white
  );
endinterface

// File: rtl/mastermind_score_engine.sv
// Mastermind scoring sequencer: latches guess/target on start, counts exact
// matches one slot per cycle, then per-color minimum overlaps one color per
// cycle, reports black/white/win with a one-cycle done pulse and logs the
// result in a small history buffer with a combinational read port.
// Optional build macro MM_EARLY_EXIT_EN: skip the color pass on a full match.
module mastermind_score_engine #(
  parameter int unsigned NUM_SLOTS   = 4,
  parameter int unsigned COLOR_W     = 3,
  parameter int unsigned MAX_GUESSES = 6
) (
  input logic                      Clk,
  input logic                      Reset,
  mastermind_score_engine_if.slave bus
);
  localparam int unsigned CODE_W  = NUM_SLOTS * COLOR_W;
  localparam int unsigned PEG_W   = $clog2(NUM_SLOTS + 1);
  localparam int unsigned COUNT_W = $clog2(MAX_GUESSES + 1);
  localparam int unsigned IDX_W   = $clog2(MAX_GUESSES);
  localparam int unsigned SLOT_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StExact = 2'd1;
  localparam logic [1:0] StColor = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]         state_q;
  logic [CODE_W-1:0]  guess_q, target_q;
  logic [SLOT_W-1:0]  slot_q;
  logic [COLOR_W-1:0] color_q;
  logic [PEG_W-1:0]   black_acc_q, total_acc_q;
  logic [PEG_W-1:0]   black_q, white_q;
  logic               win_q;

  logic [COUNT_W-1:0] hist_count_q;
  logic [CODE_W-1:0]  hist_guess_q [MAX_GUESSES];
  logic [PEG_W-1:0]   hist_black_q [MAX_GUESSES];
  logic [PEG_W-1:0]   hist_white_q [MAX_GUESSES];

  logic               exact_hit;
  logic [PEG_W-1:0]   cnt_g, cnt_t, min_gt;
  logic [PEG_W-1:0]   black_next, total_next;
  logic               hist_full;

  // Per-cycle datapath: exact match at the current slot, color overlap count
  always_comb begin
    exact_hit = 1'b0;
    cnt_g     = '0;
    cnt_t     = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_q == SLOT_W'(i)) begin
        exact_hit = (guess_q[i*COLOR_W +: COLOR_W] == target_q[i*COLOR_W +: COLOR_W]) &&
                    (guess_q[i*COLOR_W +: COLOR_W] != '0);
      end
      if (guess_q[i*COLOR_W +: COLOR_W] == color_q) cnt_g = cnt_g + PEG_W'(1);
      if (target_q[i*COLOR_W +: COLOR_W] == color_q) cnt_t = cnt_t + PEG_W'(1);
    end
    min_gt     = (cnt_g < cnt_t) ? cnt_g : cnt_t;
    black_next = black_acc_q + PEG_W'(exact_hit);
    total_next = total_acc_q + min_gt;
  end

  // Scoring FSM and result registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      guess_q     <= '0;
      target_q    <= '0;
      slot_q      <= '0;
      color_q     <= '0;
      black_acc_q <= '0;
      total_acc_q <= '0;
      black_q     <= '0;
      white_q     <= '0;
      win_q       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start && !bus.clear) begin
            guess_q     <= bus.guess;
            target_q    <= bus.target;
            slot_q      <= '0;
            color_q     <= COLOR_W'(1);
            black_acc_q <= '0;
            total_acc_q <= '0;
            state_q     <= StExact;
          end
        end
        StExact: begin
          black_acc_q <= black_next;
          if (slot_q == SLOT_W'(NUM_SLOTS - 1)) begin
`ifdef MM_EARLY_EXIT_EN
            if (black_next == PEG_W'(NUM_SLOTS)) begin
              black_q <= black_next;
              white_q <= '0;
              win_q   <= 1'b1;
              state_q <= StDone;
            end else begin
              state_q <= StColor;
            end
`else
            state_q <= StColor;
`endif
          end else begin
            slot_q <= slot_q + SLOT_W'(1);
          end
        end
        StColor: begin
          total_acc_q <= total_next;
          if (color_q == {COLOR_W{1'b1}}) begin
            // Total overlap includes exact hits; whites are the remainder
            black_q <= black_acc_q;
            white_q <= total_next - black_acc_q;
            win_q   <= (black_acc_q == PEG_W'(NUM_SLOTS));
            state_q <= StDone;
          end else begin
            color_q <= color_q + COLOR_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign hist_full = (hist_count_q == COUNT_W'(MAX_GUESSES));

  // History log: clear wins over a write landing on the same edge
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hist_count_q <= '0;
      for (int i = 0; i < MAX_GUESSES; i++) begin
        hist_guess_q[i] <= '0;
        hist_black_q[i] <= '0;
        hist_white_q[i] <= '0;
      end
    end else if (bus.clear) begin
      hist_count_q <= '0;
    end else if (state_q == StDone && !hist_full) begin
      for (int i = 0; i < MAX_GUESSES; i++) begin
        if (hist_count_q == COUNT_W'(i)) begin
          hist_guess_q[i] <= guess_q;
          hist_black_q[i] <= black_q;
          hist_white_q[i] <= white_q;
        end
      end
      hist_count_q <= hist_count_q + COUNT_W'(1);
    end
  end

  // Combinational history read port; out-of-range addresses read as zero
  always_comb begin
    bus.hist_rd_guess = '0;
    bus.hist_rd_black = '0;
    bus.hist_rd_white = '0;
    for (int i = 0; i < MAX_GUESSES; i++) begin
      if (bus.hist_rd_idx == IDX_W'(i)) begin
        bus.hist_rd_guess = hist_guess_q[i];
        bus.hist_rd_black = hist_black_q[i];
        bus.hist_rd_white = hist_white_q[i];
      end
    end
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = (state_q == StDone);
  assign bus.black      = black_q;
  assign bus.white      = white_q;
  assign bus.win        = win_q;
  assign bus.hist_count = hist_count_q;
  assign bus.hist_full  = hist_full;
endmodule
